div_sequencer: RTL

- Iterative radix-2 restoring divider controller for the M-extension DIV/DIVU/REM/REMU instructions.
- Accepts one operation at a time from issue. Sequences sign preparation, XLEN shift-subtract iterations and sign fixup.
- Reports FREE/BUSY to the scheduler using fu_state_e.
- Sits beside the MUL unit in the execute stage and writes back through the shared result bus.

---
 rtl/div_sequencer_pkg.sv | 44 ++++
 rtl/div_step.sv | 29 ++
 rtl/div_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative divider and its neighbours in execute.
// Enum encodings here are visible to the scheduler, the result bus and the bench.
package div_sequencer_pkg;

   localparam int XLEN      = 32;
   localparam int CNT_WIDTH = $clog2(XLEN);

   typedef logic [XLEN-1:0] data_bus_t;

   typedef enum logic [1:0] {
      DIV_  = 2'd0,
      DIVU_ = 2'd1,
      REM_  = 2'd2,
      REMU_ = 2'd3
   } div_ops_e;

   typedef enum logic {
      FREE = 1'b0,
      BUSY = 1'b1
   } fu_state_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PREP   = 3'd1,
      DIVIDE = 3'd2,
      FIXUP  = 3'd3,
      DONE   = 3'd4
   } div_state_e;

   localparam data_bus_t INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic op_is_signed(div_ops_e op);
      return (op == DIV_) || (op == REM_);
   endfunction

   function automatic logic op_is_rem(div_ops_e op);
      return (op == REM_) || (op == REMU_);
   endfunction

   function automatic data_bus_t abs_val(data_bus_t v);
      return v[XLEN-1] ? data_bus_t'(-v) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, set quotient bit.
// Purely combinational; relies on rem_i < divisor_i so the XLEN+1-bit difference never wraps.
module div_step
   import div_sequencer_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   assign shifted = {rem_i, quo_i[XLEN-1]};
   assign diff    = shifted - {1'b0, divisor_i};

   // Top bit of diff is the borrow: set only when the shifted remainder is below the divisor.
   always_comb begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
      if (!diff[XLEN]) begin
         rem_o = diff[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider controller for DIV/DIVU/REM/REMU; 35-cycle latency, 1 cycle for x/0 and overflow.
// Optional DIV_EARLY_OUT_EN skips the iterations when |dividend| < |divisor| (3-cycle latency).
module div_sequencer
   import div_sequencer_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic [1:0]      operation_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            kill_i,
   output logic            fu_state_o,
   output logic [XLEN-1:0] result_o,
   output logic            valid_o,
   output logic            div_by_zero_o
);

   div_state_e           state_q, state_d;
   div_ops_e             op_q, op_d, op_in;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   data_bus_t            quo_q, quo_d;
   data_bus_t            rem_q, rem_d;
   data_bus_t            dsr_q, dsr_d;
   logic                 q_neg_q, q_neg_d;
   logic                 r_neg_q, r_neg_d;
   data_bus_t            result_q, result_d;
   logic                 valid_q, valid_d;
   logic                 dbz_q, dbz_d;

   data_bus_t            step_rem, step_quo;
   data_bus_t            mag_a, mag_b;
   data_bus_t            quo_fix, rem_fix;

   assign op_in = div_ops_e'(operation_i);

   div_step u_div_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dsr_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         op_q     <= DIV_;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dsr_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dsr_q    <= dsr_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         dbz_q    <= dbz_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dsr_d    = dsr_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;
      valid_d  = 1'b0;
      dbz_d    = dbz_q;

      mag_a   = op_is_signed(op_q) ? abs_val(quo_q) : quo_q;
      mag_b   = op_is_signed(op_q) ? abs_val(dsr_q) : dsr_q;
      quo_fix = q_neg_q ? data_bus_t'(-quo_q) : quo_q;
      rem_fix = r_neg_q ? data_bus_t'(-rem_q) : rem_q;

      unique case (state_q)
         IDLE: begin
            if (valid_i && !kill_i) begin
               op_d  = op_in;
               quo_d = dividend_i;
               dsr_d = divisor_i;
               if (divisor_i == '0) begin
                  result_d = op_is_rem(op_in) ? dividend_i : '1;
                  dbz_d    = 1'b1;
                  valid_d  = 1'b1;
                  state_d  = DONE;
               end else if (op_is_signed(op_in) && (dividend_i == INT_MIN) &&
                            (divisor_i == '1)) begin
                  result_d = op_is_rem(op_in) ? '0 : INT_MIN;
                  dbz_d    = 1'b0;
                  valid_d  = 1'b1;
                  state_d  = DONE;
               end else begin
                  state_d = PREP;
               end
            end
         end
         PREP: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               quo_d   = mag_a;
               dsr_d   = mag_b;
               rem_d   = '0;
               q_neg_d = op_is_signed(op_q) && (quo_q[XLEN-1] ^ dsr_q[XLEN-1]);
               r_neg_d = op_is_signed(op_q) && quo_q[XLEN-1];
               cnt_d   = CNT_WIDTH'(XLEN-1);
               state_d = DIVIDE;
`ifdef DIV_EARLY_OUT_EN
               if (mag_a < mag_b) begin
                  quo_d   = '0;
                  rem_d   = mag_a;
                  state_d = FIXUP;
               end
`endif
            end
         end
         DIVIDE: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               quo_d = step_quo;
               rem_d = step_rem;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d = FIXUP;
               end
            end
         end
         FIXUP: begin
            if (kill_i) begin
               state_d = IDLE;
            end else begin
               result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
               dbz_d    = 1'b0;
               valid_d  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign fu_state_o    = (state_q == IDLE) ? FREE : BUSY;
   assign result_o      = result_q;
   assign valid_o       = valid_q;
   assign div_by_zero_o = dbz_q;

endmodule
